rgb2gray_uhd_4ppc: RTL and testbench
====================================

RGB2GRAY_UHD_4PPC -- requirements
Module: rgb2gray_uhd_4ppc

Interface
REQ-001 SHALL have parameter COEF_R, default 77, red luma weight (unsigned 8-bit, Q0.8).
REQ-002 SHALL have parameter COEF_G, default 150, green luma weight (unsigned 8-bit, Q0.8).
REQ-003 SHALL have parameter COEF_B, default 29, blue luma weight (unsigned 8-bit, Q0.8).
REQ-004 SHALL have port s_axis_video_aclk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port s_axis_video_reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port VIDEO_IN_tdata  input  96  4 RGB pixels; pixel k at [24k+23:24k], pixel 3 at [95:72].
REQ-007 SHALL have port VIDEO_IN_tvalid  input  1  input beat valid.
REQ-008 SHALL have port VIDEO_IN_tready  output  1  block accepts input beat.
REQ-009 SHALL have port VIDEO_IN_tuser  input  1  start of frame.
REQ-010 SHALL have port VIDEO_IN_tlast  input  1  end of line.
REQ-011 SHALL have port VIDEO_OUT_tdata  output  32  4 gray pixels; pixel k at [8k+7:8k], pixel 3 at [31:24].
REQ-012 SHALL have port VIDEO_OUT_tvalid  output  1  output beat valid.
REQ-013 SHALL have port VIDEO_OUT_tready  input  1  downstream accepts beat.
REQ-014 SHALL have port VIDEO_OUT_tuser  output  1  start of frame, aligned with its pixels.
REQ-015 SHALL have port VIDEO_OUT_tlast  output  1  end of line, aligned with its pixels.

Function
REQ-016 Within each 24-bit pixel, channel order SHALL be R=[23:16], B=[15:8], G=[7:0].
REQ-017 Each gray pixel SHALL be Y = min(255, (COEF_R*R + COEF_G*G + COEF_B*B + 128) >> 8), sum in at least 18 bits, no wrap-around.
REQ-018 All four pixels of a beat SHALL be computed in parallel, each with identical arithmetic.
REQ-019 Datapath SHALL be a 3-stage registered pipeline: S1 products, S2 rounded sum and saturation, S3 output register.
REQ-020 Each stage SHALL hold a valid bit; tuser and tlast SHALL travel with their data through every stage.
REQ-021 A beat transfers on input when VIDEO_IN_tvalid and VIDEO_IN_tready are both 1 at a clock edge, and on output when VIDEO_OUT_tvalid and VIDEO_OUT_tready are both 1.
REQ-022 Stage n SHALL load when it is empty or its content moves to stage n+1 (or out of S3) in the same cycle; otherwise it SHALL hold.
REQ-023 VIDEO_IN_tready SHALL be 1 exactly when S1 can load per REQ-022; bubbles SHALL collapse (full throughput while VIDEO_OUT_tready=1).
REQ-024 Latency SHALL be 3 cycles from input handshake to VIDEO_OUT_tvalid=1 with no backpressure; sustained throughput is 1 beat/cycle.
REQ-025 VIDEO_OUT_tdata, tuser and tlast SHALL be stable while VIDEO_OUT_tvalid=1 and VIDEO_OUT_tready=0.
REQ-026 No beat SHALL be dropped, duplicated or reordered; the block holds at most 3 beats.
REQ-027 Once VIDEO_OUT_tvalid is asserted, it SHALL NOT deassert until a handshake completes.
REQ-028 Input tdata, tuser and tlast SHALL be ignored when VIDEO_IN_tvalid=0.

Reset
REQ-029 While s_axis_video_reset=1, all stage valid bits SHALL clear at the next edge.
REQ-030 After reset, VIDEO_OUT_tvalid, VIDEO_OUT_tuser and VIDEO_OUT_tlast SHALL be 0, VIDEO_OUT_tdata SHALL be 0, and VIDEO_IN_tready SHALL be 1 from the first cycle after reset deasserts.
REQ-031 Reset mid-stream SHALL discard all in-flight beats; no partial beat SHALL appear after reset.

Verification
REQ-032 Gray input R=G=B=100 for all pixels, tready=1 -> output 0x64646464, 3 cycles after input.
REQ-033 Pixels 3..0 = pure R 255, pure G 255, pure B 255, white -> tdata {77,149,29,255} = 0x4D951DFF.
REQ-034 Stream 8 beats with a running pattern, tuser on beat 0 and tlast on beat 7; toggle VIDEO_OUT_tready randomly -> all 8 beats delivered in order, flags on beats 0 and 7 only, data stable while stalled.
REQ-035 Hold VIDEO_OUT_tready=0 with input valid -> 3 beats accepted, then VIDEO_IN_tready=0; release -> back-to-back output, no loss.
REQ-036 Assert reset with 2 beats in flight -> next cycle VIDEO_OUT_tvalid=0, VIDEO_IN_tready=1 after release, and those beats never appear.
REQ-037 Override COEF_R=COEF_G=COEF_B=255 with white input -> output 0xFF per pixel (saturation).

Source files
------------

// File: rtl/rgb2gray_uhd_4ppc.sv
// rgb2gray_uhd_4ppc: 4-pixel-per-clock RGB to luma converter, 3-stage AXI-Stream pipeline.
// Pixel channels are R=[23:16], B=[15:8], G=[7:0]; each stage loads when empty or draining.
module rgb2gray_uhd_4ppc #(
    parameter int COEF_R = 77,
    parameter int COEF_G = 150,
    parameter int COEF_B = 29
) (
    input  logic        s_axis_video_aclk,
    input  logic        s_axis_video_reset,
    input  logic [95:0] VIDEO_IN_tdata,
    input  logic        VIDEO_IN_tvalid,
    output logic        VIDEO_IN_tready,
    input  logic        VIDEO_IN_tuser,
    input  logic        VIDEO_IN_tlast,
    output logic [31:0] VIDEO_OUT_tdata,
    output logic        VIDEO_OUT_tvalid,
    input  logic        VIDEO_OUT_tready,
    output logic        VIDEO_OUT_tuser,
    output logic        VIDEO_OUT_tlast
);
    localparam logic [15:0] CR = 16'(COEF_R);
    localparam logic [15:0] CG = 16'(COEF_G);
    localparam logic [15:0] CB = 16'(COEF_B);

    logic        v1, v2, v3, u1, u2, u3, l1, l2, l3;
    logic        ld1, ld2, ld3;
    logic [15:0] pr [4];
    logic [15:0] pg [4];
    logic [15:0] pb [4];
    logic [17:0] sum [4];
    logic [31:0] y, y2, y3;

    always_comb begin
        ld3 = !v3 || VIDEO_OUT_tready;
        ld2 = !v2 || ld3;
        ld1 = !v1 || ld2;
        y = '0;
        for (int k = 0; k < 4; k++) begin
            sum[k] = 18'(pr[k]) + 18'(pg[k]) + 18'(pb[k]) + 18'd128;
            y[8*k +: 8] = |sum[k][17:16] ? 8'hFF : sum[k][15:8];
        end
        VIDEO_IN_tready  = ld1;
        VIDEO_OUT_tvalid = v3;
        VIDEO_OUT_tdata  = y3;
        VIDEO_OUT_tuser  = u3;
        VIDEO_OUT_tlast  = l3;
    end

    always_ff @(posedge s_axis_video_aclk) begin
        if (s_axis_video_reset) begin
            v1 <= 1'b0;
            u1 <= 1'b0;
            l1 <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                pr[k] <= '0;
                pg[k] <= '0;
                pb[k] <= '0;
            end
        end else if (ld1) begin
            v1 <= VIDEO_IN_tvalid;
            u1 <= VIDEO_IN_tvalid && VIDEO_IN_tuser;
            l1 <= VIDEO_IN_tvalid && VIDEO_IN_tlast;
            if (VIDEO_IN_tvalid)
                for (int k = 0; k < 4; k++) begin
                    pr[k] <= CR * {8'd0, VIDEO_IN_tdata[24*k+16 +: 8]};
                    pb[k] <= CB * {8'd0, VIDEO_IN_tdata[24*k+8 +: 8]};
                    pg[k] <= CG * {8'd0, VIDEO_IN_tdata[24*k +: 8]};
                end
        end
    end

    always_ff @(posedge s_axis_video_aclk) begin
        if (s_axis_video_reset) begin
            v2 <= 1'b0;
            u2 <= 1'b0;
            l2 <= 1'b0;
            y2 <= '0;
        end else if (ld2) begin
            v2 <= v1;
            u2 <= v1 && u1;
            l2 <= v1 && l1;
            if (v1)
                y2 <= y;
        end
    end

    always_ff @(posedge s_axis_video_aclk) begin
        if (s_axis_video_reset) begin
            v3 <= 1'b0;
            u3 <= 1'b0;
            l3 <= 1'b0;
            y3 <= '0;
        end else if (ld3) begin
            v3 <= v2;
            u3 <= v2 && u2;
            l3 <= v2 && l2;
            if (v2)
                y3 <= y2;
        end
    end
endmodule

// File: tb/tb_rgb2gray_uhd_4ppc.sv
// tb_rgb2gray_uhd_4ppc: directed self-checking bench for the RGB to luma pipeline.
// A second instance with all weights at 255 exercises output saturation.
module tb_rgb2gray_uhd_4ppc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [95:0] in_data = '0;
    logic        in_valid = 1'b0, in_user = 1'b0, in_last = 1'b0;
    logic        in_ready, out_valid, out_user, out_last;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        in_ready2, out_valid2, out_user2, out_last2;
    logic        out_ready2 = 1'b1;
    logic [31:0] out_data2;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    rgb2gray_uhd_4ppc dut (
        .s_axis_video_aclk(clk), .s_axis_video_reset(rst),
        .VIDEO_IN_tdata(in_data), .VIDEO_IN_tvalid(in_valid), .VIDEO_IN_tready(in_ready),
        .VIDEO_IN_tuser(in_user), .VIDEO_IN_tlast(in_last),
        .VIDEO_OUT_tdata(out_data), .VIDEO_OUT_tvalid(out_valid), .VIDEO_OUT_tready(out_ready),
        .VIDEO_OUT_tuser(out_user), .VIDEO_OUT_tlast(out_last)
    );

    rgb2gray_uhd_4ppc #(.COEF_R(255), .COEF_G(255), .COEF_B(255)) dut_sat (
        .s_axis_video_aclk(clk), .s_axis_video_reset(rst),
        .VIDEO_IN_tdata(in_data), .VIDEO_IN_tvalid(in_valid), .VIDEO_IN_tready(in_ready2),
        .VIDEO_IN_tuser(in_user), .VIDEO_IN_tlast(in_last),
        .VIDEO_OUT_tdata(out_data2), .VIDEO_OUT_tvalid(out_valid2), .VIDEO_OUT_tready(out_ready2),
        .VIDEO_OUT_tuser(out_user2), .VIDEO_OUT_tlast(out_last2)
    );

    // Equal channels give Y equal to the channel value with the default weights.
    function automatic logic [95:0] gb(input logic [7:0] p3, p2, p1, p0);
        return {{3{p3}}, {3{p2}}, {3{p1}}, {3{p0}}};
    endfunction

    function automatic logic [7:0] pv(input int i, input int k);
        return 8'(16 * i + 3 * k + 5);
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_user !== 1'b0 || out_last !== 1'b0)
            $display("FAIL reset_flags: got valid=%b user=%b last=%b, want 0 0 0", out_valid, out_user, out_last);
        else if (0) n_err++;
        if (out_valid !== 1'b0 || out_user !== 1'b0 || out_last !== 1'b0) n_err++;
        n_cmp++;
        if (out_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h, want 00000000", out_data);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b, want 1", in_ready);
        end
        n_cmp++;
        if (out_valid2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_sat_valid: got %b, want 0", out_valid2);
        end
    endtask

    task automatic test_gray;
        @(negedge clk);
        out_ready = 1'b1;
        in_data = gb(8'd100, 8'd100, 8'd100, 8'd100);
        in_user = 1'b0;
        in_last = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = '1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL gray_lat1: got valid=%b, want 0", out_valid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL gray_lat2: got valid=%b, want 0", out_valid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h64646464) begin
            n_err++;
            $display("FAIL gray_lat3: got valid=%b data=%h, want 1 64646464", out_valid, out_data);
        end
    endtask

    task automatic test_primaries;
        int t;
        @(negedge clk);
        out_ready = 1'b1;
        in_data = {24'hFF0000, 24'h0000FF, 24'h00FF00, 24'hFFFFFF};
        in_user = 1'b1;
        in_last = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_user = 1'b0;
        in_last = 1'b0;
        #1;
        for (t = 0; t < 10 && !out_valid; t++) begin
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h4D951DFF) begin
            n_err++;
            $display("FAIL primaries_data: got valid=%b data=%h, want 1 4D951DFF", out_valid, out_data);
        end
        n_cmp++;
        if (out_user !== 1'b1 || out_last !== 1'b1) begin
            n_err++;
            $display("FAIL primaries_flags: got user=%b last=%b, want 1 1", out_user, out_last);
        end
    endtask

    task automatic test_stream;
        int tx, rx;
        logic stalled, hu, hl, acc;
        logic [31:0] held, exp_d;
        tx = 0;
        rx = 0;
        stalled = 1'b0;
        held = '0;
        hu = 1'b0;
        hl = 1'b0;
        for (int cyc = 0; cyc < 300 && rx < 8; cyc++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            in_valid = tx < 8;
            in_data = gb(pv(tx, 3), pv(tx, 2), pv(tx, 1), pv(tx, 0));
            in_user = tx == 0;
            in_last = tx == 7;
            #1;
            if (stalled) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== held || out_user !== hu || out_last !== hl) begin
                    n_err++;
                    $display("FAIL stream_stable: got v=%b d=%h u=%b l=%b, want 1 %h %b %b",
                             out_valid, out_data, out_user, out_last, held, hu, hl);
                end
            end
            if (out_valid && out_ready) begin
                exp_d = {pv(rx, 3), pv(rx, 2), pv(rx, 1), pv(rx, 0)};
                n_cmp++;
                if (out_data !== exp_d || out_user !== (rx == 0) || out_last !== (rx == 7)) begin
                    n_err++;
                    $display("FAIL stream_beat%0d: got d=%h u=%b l=%b, want %h %b %b",
                             rx, out_data, out_user, out_last, exp_d, rx == 0, rx == 7);
                end
                rx++;
            end
            stalled = out_valid && !out_ready;
            held = out_data;
            hu = out_user;
            hl = out_last;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) tx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_user = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (rx != 8) begin
            n_err++;
            $display("FAIL stream_count: got %0d beats, want 8", rx);
        end
    endtask

    task automatic test_back_to_back;
        int acc_n;
        logic acc;
        acc_n = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = gb(8'(8'hA0 + acc_n), 8'(8'hA0 + acc_n), 8'(8'hA0 + acc_n), 8'(8'hA0 + acc_n));
            #1;
            acc = in_ready;
            @(posedge clk);
            if (acc) acc_n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (acc_n != 3 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept: got accepted=%0d ready=%b, want 3 0", acc_n, in_ready);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== {4{8'(8'hA0 + j)}}) begin
                n_err++;
                $display("FAIL bp_drain%0d: got v=%b d=%h, want 1 %h", j, out_valid, out_data, {4{8'(8'hA0 + j)}});
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_empty: got valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_reset_midstream;
        int seen;
        seen = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = gb(8'h33, 8'h33, 8'h33, 8'h33);
        @(negedge clk);
        in_data = gb(8'h44, 8'h44, 8'h44, 8'h44);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_valid: got %b, want 0", out_valid);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_ready: got %b, want 1", in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL rst_mid_ghost: got %0d valid cycles, want 0", seen);
        end
    endtask

    task automatic test_saturation;
        int t;
        @(negedge clk);
        out_ready = 1'b1;
        in_data = '1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        for (t = 0; t < 10 && !out_valid2; t++) begin
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (out_valid2 !== 1'b1 || out_data2 !== 32'hFFFFFFFF) begin
            n_err++;
            $display("FAIL sat_data: got v=%b d=%h, want 1 FFFFFFFF", out_valid2, out_data2);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFF) begin
            n_err++;
            $display("FAIL white_default: got v=%b d=%h, want 1 FFFFFFFF", out_valid, out_data);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_gray();
        test_primaries();
        test_stream();
        test_back_to_back();
        test_reset_midstream();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
